// File: rtl/irq_ctrl.sv
// irq_ctrl: builds mip_next from synchronized PLIC levels, timer compares and msip, then arbitrates one interrupt trap request.
// Latency: ext level -> mip_next 2 cycles; timer compare -> mip_next 1 cycle; mip_q -> irq_req 1 cycle; mip_q & mie -> wfi_wake 1 cycle.
// Backpressure: irq_req/irq_cause hold until irq_ack or until the candidate is withdrawn; each ack is followed by a 2-cycle holdoff.
// Ports: clk/rst (sync, active-high); CSR inputs mip_q, mie, mideleg, mstatus, privilege_mode, menvcfgh;
//        timer inputs timer_counter, mtimecmp, stimecmp/stimecmph; msip, ext_meip_async, ext_seip_async; irq_ack;
//        outputs mip_next (comb), irq_req, irq_cause, wfi_wake (registered).
module irq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mip_q,
   input  logic [31:0] mie,
   input  logic [31:0] mideleg,
   input  logic [31:0] mstatus,
   input  logic [1:0]  privilege_mode,
   input  logic [63:0] timer_counter,
   input  logic [63:0] mtimecmp,
   input  logic [31:0] stimecmp,
   input  logic [31:0] stimecmph,
   input  logic [31:0] menvcfgh,
   input  logic        msip,
   input  logic        ext_meip_async,
   input  logic        ext_seip_async,
   input  logic        irq_ack,
   output logic [31:0] mip_next,
   output logic        irq_req,
   output logic [31:0] irq_cause,
   output logic        wfi_wake
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;

   // Input vector is pre-ordered by priority: MEIP, MSIP, MTIP, SEIP, SSIP, STIP.
   function automatic logic [3:0] first_code(input logic [5:0] v);
      logic [3:0] c;
      c = 4'd0;
      if      (v[5]) c = 4'd11;
      else if (v[4]) c = 4'd3;
      else if (v[3]) c = 4'd7;
      else if (v[2]) c = 4'd9;
      else if (v[1]) c = 4'd1;
      else if (v[0]) c = 4'd5;
      return c;
   endfunction

   logic        meip_meta_q, meip_meta_d, meip_s_q, meip_s_d;
   logic        seip_meta_q, seip_meta_d, seip_s_q, seip_s_d;
   logic        mtip_q, mtip_d, stip_q, stip_d, msip_q, msip_d;
   state_t      state_q, state_d;
   logic [1:0]  hold_cnt_q, hold_cnt_d;
   logic        irq_req_q, irq_req_d;
   logic [31:0] irq_cause_q, irq_cause_d;
   logic        wfi_wake_q, wfi_wake_d;

   logic [5:0]  pend6, deleg6, mpend6, spend6;
   logic        m_elig, s_elig, cand_valid;
   logic [3:0]  cand_code;

   // Only the standard interrupt bits and the MIE/SIE/STCE enables matter here.
   logic unused_bits;
   assign unused_bits = ^{mstatus[31:4], mstatus[2], mstatus[0], menvcfgh[30:0],
                          mideleg[31:12], mideleg[10], mideleg[8], mideleg[6],
                          mideleg[4], mideleg[2], mideleg[0]};

   // Input conditioning and mip_next
   always_comb begin
      meip_meta_d = ext_meip_async;
      meip_s_d    = meip_meta_q;
      seip_meta_d = ext_seip_async;
      seip_s_d    = seip_meta_q;
      mtip_d      = (timer_counter >= mtimecmp);
      stip_d      = (timer_counter >= {stimecmph, stimecmp});
      msip_d      = msip;
      wfi_wake_d  = |(mip_q & mie);

      mip_next     = 32'd0;
      mip_next[11] = meip_s_q;
      mip_next[9]  = seip_s_q;
      mip_next[7]  = mtip_q;
      // Without STCE the CSR unit owns STIP, so it is passed through.
      mip_next[5]  = menvcfgh[31] ? stip_q : mip_q[5];
      mip_next[3]  = msip_q;
      mip_next[1]  = mip_q[1];
   end

   // Arbitration
   always_comb begin
      pend6  = {mip_q[11] & mie[11], mip_q[3] & mie[3], mip_q[7] & mie[7],
                mip_q[9]  & mie[9],  mip_q[1] & mie[1], mip_q[5] & mie[5]};
      deleg6 = {mideleg[11], mideleg[3], mideleg[7], mideleg[9], mideleg[1], mideleg[5]};
      mpend6 = pend6 & ~deleg6;
      spend6 = pend6 & deleg6;
      m_elig = (privilege_mode != PRIV_M) || mstatus[3];
      s_elig = (privilege_mode == PRIV_U) || ((privilege_mode == PRIV_S) && mstatus[1]);

      cand_valid = 1'b0;
      cand_code  = 4'd0;
      if (m_elig && (|mpend6)) begin
         cand_valid = 1'b1;
         cand_code  = first_code(mpend6);
      end else if (s_elig && (|spend6)) begin
         cand_valid = 1'b1;
         cand_code  = first_code(spend6);
      end
   end

   // Request FSM
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      irq_req_d   = irq_req_q;
      irq_cause_d = irq_cause_q;
      case (state_q)
         IDLE: begin
            if (cand_valid) begin
               irq_req_d   = 1'b1;
               irq_cause_d = {1'b1, 27'd0, cand_code};
               state_d     = REQ;
            end
         end
         REQ: begin
            // Ack has priority over withdrawal: the latched cause is taken.
            if (irq_ack) begin
               irq_req_d  = 1'b0;
               hold_cnt_d = 2'd2;
               state_d    = HOLD;
            end else if (!cand_valid) begin
               irq_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         HOLD: begin
            // Lets the trap's mstatus/privilege update reach our inputs before re-arbitrating.
            irq_req_d = 1'b0;
            if (hold_cnt_q == 2'd1) state_d = IDLE;
            else                    hold_cnt_d = hold_cnt_q - 2'd1;
         end
         default: begin
            irq_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meip_meta_q <= 1'b0;
         meip_s_q    <= 1'b0;
         seip_meta_q <= 1'b0;
         seip_s_q    <= 1'b0;
         mtip_q      <= 1'b0;
         stip_q      <= 1'b0;
         msip_q      <= 1'b0;
         state_q     <= IDLE;
         hold_cnt_q  <= 2'd0;
         irq_req_q   <= 1'b0;
         irq_cause_q <= 32'd0;
         wfi_wake_q  <= 1'b0;
      end else begin
         meip_meta_q <= meip_meta_d;
         meip_s_q    <= meip_s_d;
         seip_meta_q <= seip_meta_d;
         seip_s_q    <= seip_s_d;
         mtip_q      <= mtip_d;
         stip_q      <= stip_d;
         msip_q      <= msip_d;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         irq_req_q   <= irq_req_d;
         irq_cause_q <= irq_cause_d;
         wfi_wake_q  <= wfi_wake_d;
      end
   end

   assign irq_req   = irq_req_q;
   assign irq_cause = irq_cause_q;
   assign wfi_wake  = wfi_wake_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mip_q, mie, mideleg, mstatus;
   logic [1:0]  privilege_mode;
   logic [63:0] timer_counter, mtimecmp;
   logic [31:0] stimecmp, stimecmph, menvcfgh;
   logic        msip, ext_meip_async, ext_seip_async, irq_ack;
   logic [31:0] mip_next;
   logic        irq_req;
   logic [31:0] irq_cause;
   logic        wfi_wake;

   always #5 clk = ~clk;

   irq_ctrl dut (
      .clk(clk), .rst(rst), .mip_q(mip_q), .mie(mie), .mideleg(mideleg), .mstatus(mstatus),
      .privilege_mode(privilege_mode), .timer_counter(timer_counter), .mtimecmp(mtimecmp),
      .stimecmp(stimecmp), .stimecmph(stimecmph), .menvcfgh(menvcfgh), .msip(msip),
      .ext_meip_async(ext_meip_async), .ext_seip_async(ext_seip_async), .irq_ack(irq_ack),
      .mip_next(mip_next), .irq_req(irq_req), .irq_cause(irq_cause), .wfi_wake(wfi_wake)
   );

   typedef struct {
      logic [31:0] mip_next;
      logic        req;
      logic [31:0] cause;
      logic        wfi;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   int          prio[6] = '{11, 3, 7, 9, 1, 5};
   logic        meip_line[$];
   logic        seip_line[$];
   logic        m_meip, m_seip, m_mtip, m_stip, m_msip, m_wfi, m_req;
   logic [31:0] m_cause;
   int          m_quiet;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endfunction

   // Winner among enabled pending interrupts: {valid, code}.
   function automatic logic [4:0] arbitrate();
      logic [31:0] pend;
      logic        m_ok, s_ok, v;
      logic [3:0]  c;
      pend = mip_q & mie & 32'h0AAA;
      m_ok = (privilege_mode != 2'd3) || mstatus[3];
      s_ok = (privilege_mode == 2'd0) || (privilege_mode == 2'd1 && mstatus[1]);
      v = 1'b0;
      c = 4'd0;
      for (int i = 0; i < 6; i++)
         if (!v && m_ok && pend[prio[i]] && !mideleg[prio[i]]) begin v = 1'b1; c = 4'(prio[i]); end
      for (int i = 0; i < 6; i++)
         if (!v && s_ok && pend[prio[i]] && mideleg[prio[i]]) begin v = 1'b1; c = 4'(prio[i]); end
      return {v, c};
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_edge();
      logic [4:0]  w;
      exp_t        e;
      w = arbitrate();
      if (rst) begin
         meip_line = '{1'b0};
         seip_line = '{1'b0};
         m_meip = 0; m_seip = 0; m_mtip = 0; m_stip = 0; m_msip = 0; m_wfi = 0;
         m_req = 0; m_cause = 0; m_quiet = 0;
      end else begin
         meip_line.push_back(ext_meip_async);
         m_meip = meip_line.pop_front();
         seip_line.push_back(ext_seip_async);
         m_seip = seip_line.pop_front();
         m_mtip = (timer_counter >= mtimecmp);
         m_stip = (timer_counter >= {stimecmph, stimecmp});
         m_msip = msip;
         m_wfi  = |(mip_q & mie);
         if (m_req) begin
            if (irq_ack) begin m_req = 0; m_quiet = 2; end
            else if (!w[4]) m_req = 0;
         end else if (m_quiet > 0) begin
            m_quiet--;
         end else if (w[4]) begin
            m_req   = 1;
            m_cause = {1'b1, 27'd0, w[3:0]};
         end
      end
      e.mip_next     = 32'd0;
      e.mip_next[11] = m_meip;
      e.mip_next[9]  = m_seip;
      e.mip_next[7]  = m_mtip;
      e.mip_next[5]  = menvcfgh[31] ? m_stip : mip_q[5];
      e.mip_next[3]  = m_msip;
      e.mip_next[1]  = mip_q[1];
      e.req   = m_req;
      e.cause = m_cause;
      e.wfi   = m_wfi;
      exp_q.push_back(e);
   endfunction

   // Monitor: every edge the DUT presents a new output set; compare against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_mip_next", mip_next, e.mip_next);
            chk("sb_irq_req", 32'(irq_req), 32'(e.req));
            chk("sb_irq_cause", irq_cause, e.cause);
            chk("sb_wfi_wake", 32'(wfi_wake), 32'(e.wfi));
         end
      end
   end

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      irq_ack = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mip_q = 0; mie = 0; mideleg = 0; mstatus = 0; privilege_mode = 2'd3;
      timer_counter = 0; mtimecmp = '1; stimecmp = '1; stimecmph = '1; menvcfgh = 0;
      msip = 0; ext_meip_async = 0; ext_seip_async = 0; irq_ack = 0;
      meip_line = '{1'b0};
      seip_line = '{1'b0};

      // Reset values, with everything pending on mip_q
      mip_q = 32'hFFFF_FFFF; mie = 32'hFFFF_FFFF; menvcfgh = 32'h8000_0000;
      step();
      chk("rst_mip_next_stce", mip_next, 32'h2);
      chk("rst_irq_req", 32'(irq_req), 0);
      chk("rst_irq_cause", irq_cause, 0);
      chk("rst_wfi", 32'(wfi_wake), 0);
      menvcfgh = 0;
      step();
      chk("rst_mip_next_nostce", mip_next, 32'h22);
      mip_q = 0; mie = 0;
      rst = 1'b0;

      // Machine timer with mip looped back
      mtimecmp = 64'd100; mie = 32'h80; mstatus = 32'h8; privilege_mode = 2'd3;
      for (int k = 0; k < 6; k++) begin
         timer_counter = 64'(98 + k);
         mip_q = mip_next;
         step();
         if (k == 1) chk("mtip_before", 32'(mip_next[7]), 0);
         if (k == 2) chk("mtip_at", 32'(mip_next[7]), 1);
      end
      chk("mt_req", 32'(irq_req), 1);
      chk("mt_cause", irq_cause, 32'h8000_0007);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("mt_hold0", 32'(irq_req), 0);
      step(); chk("mt_hold1", 32'(irq_req), 0);
      step(); chk("mt_hold2", 32'(irq_req), 0);
      step(); chk("mt_rereq", 32'(irq_req), 1);
      do_reset();

      // Priority: MEIP over MSIP over MTIP in U mode
      mtimecmp = '1; privilege_mode = 2'd0; mstatus = 0; mideleg = 0;
      mie = 32'h888; mip_q = 32'h888;
      step();
      chk("prio_cause_meip", irq_cause, 32'h8000_000B);
      irq_ack = 1'b1; mie = 32'h088; step(); irq_ack = 1'b0;
      step(); step(); step();
      chk("prio_req2", 32'(irq_req), 1);
      chk("prio_cause_msip", irq_cause, 32'h8000_0003);
      do_reset();

      // Delegation of STIP via Sstc
      mideleg = 32'h20; menvcfgh = 32'h8000_0000; stimecmp = 0; stimecmph = 0;
      timer_counter = 64'd50; mie = 32'h20; mstatus = 0; privilege_mode = 2'd1; mip_q = 0;
      step();
      chk("stip_mip_next", 32'(mip_next[5]), 1);
      mip_q = 32'h20;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("deleg_s_sie0", 32'(irq_req), 0);
      end
      privilege_mode = 2'd0;
      step();
      chk("deleg_u_req", 32'(irq_req), 1);
      chk("deleg_u_cause", irq_cause, 32'h8000_0005);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      privilege_mode = 2'd3;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("deleg_m_noreq", 32'(irq_req), 0);
      end
      chk("deleg_m_wfi", 32'(wfi_wake), 1);
      menvcfgh = 0; mip_q = 0;
      step();
      chk("stce_off", 32'(mip_next[5]), 0);
      do_reset();

      // Withdrawal, and ack in the same cycle as withdrawal
      privilege_mode = 2'd3; mstatus = 32'h8; mideleg = 0; mie = 32'h8; mip_q = 32'h8;
      step();
      chk("wd_req", 32'(irq_req), 1);
      mie = 0; step();
      chk("wd_drop", 32'(irq_req), 0);
      chk("wd_cause_kept", irq_cause, 32'h8000_0003);
      mie = 32'h8; step();
      chk("wd_idle_rereq", 32'(irq_req), 1);
      mie = 0; irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("wdack_drop", 32'(irq_req), 0);
      mie = 32'h8;
      step(); chk("wdack_hold1", 32'(irq_req), 0);
      step(); chk("wdack_hold2", 32'(irq_req), 0);
      step(); chk("wdack_rereq", 32'(irq_req), 1);

      // Synchronizer latency
      ext_seip_async = 1'b1;
      step(); chk("seip_rise_1", 32'(mip_next[9]), 0);
      step(); chk("seip_rise_2", 32'(mip_next[9]), 1);
      ext_seip_async = 1'b0;
      step(); chk("seip_fall_1", 32'(mip_next[9]), 1);
      step(); chk("seip_fall_2", 32'(mip_next[9]), 0);
      ext_meip_async = 1'b1;
      step(); step(); chk("meip_rise_2", 32'(mip_next[11]), 1);
      ext_meip_async = 1'b0;

      // Reset while a request is outstanding
      mip_q = 32'h2A;
      step();
      chk("rr_req_before", 32'(irq_req), 1);
      rst = 1'b1; step();
      chk("rr_req", 32'(irq_req), 0);
      chk("rr_cause", irq_cause, 0);
      chk("rr_wfi", 32'(wfi_wake), 0);
      chk("rr_mip_next", mip_next, 32'h22);
      rst = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 3) == 0) mip_q = $urandom & ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'h0000_0AAA);
         if ($urandom_range(0, 5) == 0) mie = $urandom;
         if ($urandom_range(0, 15) == 0) mideleg = $urandom;
         if ($urandom_range(0, 7) == 0) mstatus = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: privilege_mode = 2'd0;
               1: privilege_mode = 2'd1;
               default: privilege_mode = 2'd3;
            endcase
         end
         if ($urandom_range(0, 9) == 0) menvcfgh = $urandom;
         timer_counter = 64'h1_0000_0000 + 64'($urandom_range(0, 40));
         if ($urandom_range(0, 9) == 0) mtimecmp = 64'h1_0000_0000 + 64'($urandom_range(0, 40));
         if ($urandom_range(0, 9) == 0) begin
            stimecmph = $urandom_range(0, 2);
            stimecmp  = $urandom_range(0, 40);
         end
         msip = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) ext_meip_async = ~ext_meip_async;
         if ($urandom_range(0, 3) == 0) ext_seip_async = ~ext_seip_async;
         irq_ack = ($urandom_range(0, 2) == 0);
         step();
      end
      rst = 1'b0; irq_ack = 1'b0;
      step();
      chk("sb_drained", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
